// File: rtl/rx_pll_phase_ctrl.sv
// rx_pll_phase_ctrl: sequences DRP phase/inversion updates of the RX user-clock PLL per command.
module rx_pll_phase_ctrl #(
  parameter int CLK0_HIGH    = 2,
  parameter int CLK0_LOW     = 2,
  parameter int CLK1_HIGH    = 4,
  parameter int CLK1_LOW     = 4,
  parameter int RST_CYCLES   = 16,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        drpclk,
  input  logic        reset_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_phase0,
  input  logic [8:0]  cmd_phase1,
  input  logic [1:0]  cmd_inv,
  output logic        pll_reset_out,
  output logic        drpen,
  output logic        drpwe,
  output logic [6:0]  drpaddr,
  output logic [15:0] drpdi,
  input  logic        drprdy,
  input  logic        rx_active_in,
  output logic        inv_rxusrclk,
  output logic        inv_rxusrclk2,
  output logic        busy,
  output logic        done,
  output logic        err_drp,
  output logic        err_lock
);
  typedef enum logic [2:0] {IDLE, RST_HOLD, WR, WAIT_RDY, RELEASE, WAIT_LOCK, APPLY_INV, FINISH} state_t;
  localparam logic [5:0] H0 = 6'(CLK0_HIGH);
  localparam logic [5:0] L0 = 6'(CLK0_LOW);
  localparam logic [5:0] H1 = 6'(CLK1_HIGH);
  localparam logic [5:0] L1 = 6'(CLK1_LOW);
  state_t state_q, state_d;
  logic [16:0] tmr_q, tmr_d;
  logic [1:0]  idx_q, idx_d;
  logic [8:0]  ph0_q, ph0_d, ph1_q, ph1_d;
  logic [1:0]  inv_tgt_q, inv_tgt_d, inv_q, inv_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] di_q, di_d;
  logic        err_drp_q, err_drp_d, err_lock_q, err_lock_d;
  (* ASYNC_REG = "TRUE" *) logic act_m_q;
  (* ASYNC_REG = "TRUE" *) logic act_s_q;

  function automatic logic [15:0] img(logic [1:0] i, logic [8:0] p0, logic [8:0] p1);
    logic [8:0] p;
    p = i[1] ? p1 : p0;
    return i[0] ? {10'b0, p[5:0]} : {p[8:6], 1'b0, i[1] ? H1 : H0, i[1] ? L1 : L0};
  endfunction

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    ph0_d      = ph0_q;
    ph1_d      = ph1_q;
    inv_tgt_d  = inv_tgt_q;
    inv_d      = inv_q;
    addr_d     = addr_q;
    di_d       = di_q;
    err_drp_d  = err_drp_q;
    err_lock_d = err_lock_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        ph0_d      = cmd_phase0;
        ph1_d      = cmd_phase1;
        inv_tgt_d  = cmd_inv;
        err_drp_d  = 1'b0;
        err_lock_d = 1'b0;
        tmr_d      = '0;
        idx_d      = '0;
        state_d    = RST_HOLD;
      end
      RST_HOLD: if (tmr_q == 17'(RST_CYCLES - 1)) begin
        tmr_d   = '0;
        state_d = WR;
      end else tmr_d = tmr_q + 17'd1;
      WR: begin
        tmr_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: if (drprdy) begin
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? RELEASE : WR;
      end else if (tmr_q == 17'(DRP_TIMEOUT - 1)) begin
        err_drp_d = 1'b1;
        state_d   = FINISH;
      end else tmr_d = tmr_q + 17'd1;
      RELEASE: begin
        tmr_d   = '0;
        state_d = WAIT_LOCK;
      end
      // the first four cycles ignore active_s, which may still hold the pre-reset value
      WAIT_LOCK: if (tmr_q < 17'd4) tmr_d = tmr_q + 17'd1;
      else if (act_s_q) begin
        inv_d   = inv_tgt_q;
        state_d = APPLY_INV;
      end else if (tmr_q == 17'(LOCK_TIMEOUT + 3)) begin
        err_lock_d = 1'b1;
        state_d    = FINISH;
      end else tmr_d = tmr_q + 17'd1;
      APPLY_INV: state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (state_d == WR) begin
      addr_d = {5'b00010, idx_d};
      di_d   = img(idx_d, ph0_d, ph1_d);
    end
  end

  always_ff @(posedge drpclk) begin
    if (reset_in) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      ph0_q      <= '0;
      ph1_q      <= '0;
      inv_tgt_q  <= '0;
      inv_q      <= '0;
      addr_q     <= '0;
      di_q       <= '0;
      err_drp_q  <= 1'b0;
      err_lock_q <= 1'b0;
      act_m_q    <= 1'b0;
      act_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      ph0_q      <= ph0_d;
      ph1_q      <= ph1_d;
      inv_tgt_q  <= inv_tgt_d;
      inv_q      <= inv_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      err_drp_q  <= err_drp_d;
      err_lock_q <= err_lock_d;
      act_m_q    <= rx_active_in;
      act_s_q    <= act_m_q;
    end
  end

  assign cmd_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign done          = state_q == FINISH;
  assign drpen         = state_q == WR;
  assign drpwe         = drpen;
  assign pll_reset_out = state_q inside {RST_HOLD, WR, WAIT_RDY};
  assign drpaddr       = addr_q;
  assign drpdi         = di_q;
  assign inv_rxusrclk  = inv_q[0];
  assign inv_rxusrclk2 = inv_q[1];
  assign err_drp       = err_drp_q;
  assign err_lock      = err_lock_q;
endmodule
